// File: rtl/noc_pkg.sv
// Shared types and helpers for the 4x4 mesh NoC.
// Flit header, port enum, XY routing and round-robin step.
package noc_pkg;

   localparam int BUS_WIDTH  = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int N          = 4;
   localparam int CW         = 2;
   localparam int NP         = 5;

   localparam int ROW_HI = 31;
   localparam int ROW_LO = 30;
   localparam int COL_HI = 29;
   localparam int COL_LO = 28;

   typedef logic [CW-1:0] coord_t;

   typedef enum logic [2:0] {
      P_LOCAL,
      P_NORTH,
      P_EAST,
      P_SOUTH,
      P_WEST
   } port_e;

   function automatic port_e xy_route(
      input coord_t dest_row,
      input coord_t dest_col,
      input coord_t row,
      input coord_t col
   );
      port_e p;
      p = P_LOCAL;
      unique case (1'b1)
         dest_col > col: p = P_EAST;
         dest_col < col: p = P_WEST;
         dest_col == col && dest_row > row: p = P_SOUTH;
         dest_col == col && dest_row < row: p = P_NORTH;
         default: p = P_LOCAL;
      endcase
      return p;
   endfunction

   function automatic logic [2:0] rr_idx(
      input logic [2:0] base,
      input int         k
   );
      int s;
      s = int'(base) + k;
      if (s >= NP) s = s - NP;
      return 3'(s);
   endfunction

endpackage

// File: rtl/noc_router.sv
// One mesh router: five input FIFOs, XY route, per-output
// round-robin arbiters, crossbar and registered local eject.
module noc_router
   import noc_pkg::*;
#(
   parameter int ROW = 0,
   parameter int COL = 0
) (
   input  logic                         clk1,
   input  logic                         rst,
   input  logic [NP-1:0][BUS_WIDTH-1:0] in_data,
   input  logic [NP-1:0]                nbr_full,
   output logic [NP-1:0][BUS_WIDTH-1:0] out_data,
   output logic [NP-1:0]                in_full
);

   localparam int     AW     = $clog2(FIFO_DEPTH);
   localparam coord_t MY_ROW = coord_t'(ROW);
   localparam coord_t MY_COL = coord_t'(COL);

   logic [BUS_WIDTH-1:0]         mem [NP][FIFO_DEPTH];
   logic [NP-1:0][AW-1:0]        rptr;
   logic [NP-1:0][AW-1:0]        wptr;
   logic [NP-1:0][AW:0]          cnt;
   logic [NP-1:0][BUS_WIDTH-1:0] head;
   logic [NP-1:0][BUS_WIDTH-1:0] xbar;
   logic [NP-1:0]                push;
   logic [NP-1:0]                pop;
   logic [NP-1:0]                empty;
   logic [NP-1:0]                gnt_v;
   logic [NP-1:0]                go;
   logic [NP-1:0][NP-1:0]        req;
   logic [NP-1:0][2:0]           ptr;
   logic [NP-1:0][2:0]           gnt_i;
   logic [BUS_WIDTH-1:0]         eject_q;
   port_e                        route [NP];

   // FIFO status, accept decision and route of each head
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         head[i]    = mem[i][rptr[i]];
         empty[i]   = cnt[i] == '0;
         in_full[i] = cnt[i] == (AW+1)'(FIFO_DEPTH);
         push[i]    = in_data[i] != '0 && !in_full[i];
         route[i]   = xy_route(head[i][ROW_HI:ROW_LO],
                               head[i][COL_HI:COL_LO],
                               MY_ROW, MY_COL);
      end
   end

   // Arbitrate each output, move granted heads when downstream has room
   always_comb begin
      req      = '0;
      gnt_v    = '0;
      gnt_i    = '0;
      go       = '0;
      pop      = '0;
      xbar     = '0;
      out_data = '0;
      for (int o = 0; o < NP; o++) begin
         for (int i = 0; i < NP; i++) begin
            req[o][i] = !empty[i] && route[i] == port_e'(o);
         end
         for (int k = 0; k < NP; k++) begin
            if (!gnt_v[o] && req[o][rr_idx(ptr[o], k)]) begin
               gnt_v[o] = 1'b1;
               gnt_i[o] = rr_idx(ptr[o], k);
            end
         end
         go[o]   = gnt_v[o] && !nbr_full[o];
         xbar[o] = head[gnt_i[o]];
         if (go[o]) pop[gnt_i[o]] = 1'b1;
         if (o != int'(P_LOCAL) && go[o]) out_data[o] = xbar[o];
      end
      out_data[P_LOCAL] = eject_q;
   end

   // FIFO pointers, counts, arbiter pointers and eject register
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         rptr    <= '0;
         wptr    <= '0;
         cnt     <= '0;
         ptr     <= {NP{3'(P_LOCAL)}};
         eject_q <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (push[i]) wptr[i] <= wptr[i] + AW'(1);
            if (pop[i])  rptr[i] <= rptr[i] + AW'(1);
            cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
         end
         for (int o = 0; o < NP; o++) begin
            if (go[o]) ptr[o] <= rr_idx(gnt_i[o], 1);
         end
         eject_q <= go[P_LOCAL] ? xbar[P_LOCAL] : '0;
      end
   end

   // FIFO storage write
   always_ff @(posedge clk1) begin
      for (int i = 0; i < NP; i++) begin
         if (push[i]) mem[i][wptr[i]] <= in_data[i];
      end
   end

endmodule

// File: rtl/noc_mesh_4x4.sv
// 4x4 mesh of XY routers with full-flag backpressure.
// Node id = row*4 + col; edge links are tied off.
module noc_mesh_4x4
   import noc_pkg::*;
(
   input  logic        clk1,
   input  logic        rst,
   input  logic [31:0] router_in00,
   input  logic [31:0] router_in01,
   input  logic [31:0] router_in02,
   input  logic [31:0] router_in03,
   input  logic [31:0] router_in10,
   input  logic [31:0] router_in11,
   input  logic [31:0] router_in12,
   input  logic [31:0] router_in13,
   input  logic [31:0] router_in20,
   input  logic [31:0] router_in21,
   input  logic [31:0] router_in22,
   input  logic [31:0] router_in23,
   input  logic [31:0] router_in30,
   input  logic [31:0] router_in31,
   input  logic [31:0] router_in32,
   input  logic [31:0] router_in33,
   input  logic        buffer_in00,
   input  logic        buffer_in01,
   input  logic        buffer_in02,
   input  logic        buffer_in03,
   input  logic        buffer_in10,
   input  logic        buffer_in11,
   input  logic        buffer_in12,
   input  logic        buffer_in13,
   input  logic        buffer_in20,
   input  logic        buffer_in21,
   input  logic        buffer_in22,
   input  logic        buffer_in23,
   input  logic        buffer_in30,
   input  logic        buffer_in31,
   input  logic        buffer_in32,
   input  logic        buffer_in33,
   output logic        buffer_out00,
   output logic        buffer_out01,
   output logic        buffer_out02,
   output logic        buffer_out03,
   output logic        buffer_out10,
   output logic        buffer_out11,
   output logic        buffer_out12,
   output logic        buffer_out13,
   output logic        buffer_out20,
   output logic        buffer_out21,
   output logic        buffer_out22,
   output logic        buffer_out23,
   output logic        buffer_out30,
   output logic        buffer_out31,
   output logic        buffer_out32,
   output logic        buffer_out33,
   output logic [31:0] router_out00,
   output logic [31:0] router_out01,
   output logic [31:0] router_out02,
   output logic [31:0] router_out03,
   output logic [31:0] router_out10,
   output logic [31:0] router_out11,
   output logic [31:0] router_out12,
   output logic [31:0] router_out13,
   output logic [31:0] router_out20,
   output logic [31:0] router_out21,
   output logic [31:0] router_out22,
   output logic [31:0] router_out23,
   output logic [31:0] router_out30,
   output logic [31:0] router_out31,
   output logic [31:0] router_out32,
   output logic [31:0] router_out33
);

   logic [15:0][BUS_WIDTH-1:0]         rin;
   logic [15:0][BUS_WIDTH-1:0]         rout;
   logic [15:0]                        bin;
   logic [15:0]                        bout;
   logic [15:0][NP-1:0][BUS_WIDTH-1:0] id;
   logic [15:0][NP-1:0][BUS_WIDTH-1:0] od;
   logic [15:0][NP-1:0]                nf;
   logic [15:0][NP-1:0]                fl;

   assign rin = {router_in33, router_in32, router_in31, router_in30,
                 router_in23, router_in22, router_in21, router_in20,
                 router_in13, router_in12, router_in11, router_in10,
                 router_in03, router_in02, router_in01, router_in00};

   assign bin = {buffer_in33, buffer_in32, buffer_in31, buffer_in30,
                 buffer_in23, buffer_in22, buffer_in21, buffer_in20,
                 buffer_in13, buffer_in12, buffer_in11, buffer_in10,
                 buffer_in03, buffer_in02, buffer_in01, buffer_in00};

   assign router_out00 = rout[0];
   assign router_out01 = rout[1];
   assign router_out02 = rout[2];
   assign router_out03 = rout[3];
   assign router_out10 = rout[4];
   assign router_out11 = rout[5];
   assign router_out12 = rout[6];
   assign router_out13 = rout[7];
   assign router_out20 = rout[8];
   assign router_out21 = rout[9];
   assign router_out22 = rout[10];
   assign router_out23 = rout[11];
   assign router_out30 = rout[12];
   assign router_out31 = rout[13];
   assign router_out32 = rout[14];
   assign router_out33 = rout[15];

   assign {buffer_out33, buffer_out32, buffer_out31, buffer_out30,
           buffer_out23, buffer_out22, buffer_out21, buffer_out20,
           buffer_out13, buffer_out12, buffer_out11, buffer_out10,
           buffer_out03, buffer_out02, buffer_out01, buffer_out00} = bout;

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         localparam int ID = r*N + c;

         assign id[ID][P_LOCAL] = rin[ID];
         assign nf[ID][P_LOCAL] = bin[ID];
         assign rout[ID]        = od[ID][P_LOCAL];
         assign bout[ID]        = fl[ID][P_LOCAL];

         if (r > 0) begin : g_n
            assign id[ID][P_NORTH] = od[ID-N][P_SOUTH];
            assign nf[ID][P_NORTH] = fl[ID-N][P_SOUTH];
         end else begin : g_n_edge
            assign id[ID][P_NORTH] = '0;
            assign nf[ID][P_NORTH] = 1'b1;
         end

         if (r < N-1) begin : g_s
            assign id[ID][P_SOUTH] = od[ID+N][P_NORTH];
            assign nf[ID][P_SOUTH] = fl[ID+N][P_NORTH];
         end else begin : g_s_edge
            assign id[ID][P_SOUTH] = '0;
            assign nf[ID][P_SOUTH] = 1'b1;
         end

         if (c < N-1) begin : g_e
            assign id[ID][P_EAST] = od[ID+1][P_WEST];
            assign nf[ID][P_EAST] = fl[ID+1][P_WEST];
         end else begin : g_e_edge
            assign id[ID][P_EAST] = '0;
            assign nf[ID][P_EAST] = 1'b1;
         end

         if (c > 0) begin : g_w
            assign id[ID][P_WEST] = od[ID-1][P_EAST];
            assign nf[ID][P_WEST] = fl[ID-1][P_EAST];
         end else begin : g_w_edge
            assign id[ID][P_WEST] = '0;
            assign nf[ID][P_WEST] = 1'b1;
         end

         noc_router #(
            .ROW(r),
            .COL(c)
         ) u_rtr (
            .clk1    (clk1),
            .rst     (rst),
            .in_data (id[ID]),
            .nbr_full(nf[ID]),
            .out_data(od[ID]),
            .in_full (fl[ID])
         );
      end
   end

endmodule

// File: tb/tb_noc_mesh_4x4.sv
// Scoreboard bench for the 4x4 mesh: latency, stall,
// hotspot, random traffic and mid-run reset.
module tb_noc_mesh_4x4;

   logic        clk1 = 1'b0;
   logic        rst  = 1'b1;
   logic [31:0] rin [16];
   logic [15:0] bin;
   wire  [31:0] rout [16];
   wire  [15:0] bout;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_del [16];
   int          del_cyc [16];
   int          tot_del = 0;
   logic [31:0] sb [16][$];
   int          mi;
   int          cap, b, acc, seq, k, left;
   logic [3:0]  dst;
   logic [31:0] w;

   always #5 clk1 = ~clk1;

   always @(posedge clk1) cyc++;

   noc_mesh_4x4 dut (
      .clk1(clk1), .rst(rst),
      .router_in00(rin[0]),  .router_in01(rin[1]),
      .router_in02(rin[2]),  .router_in03(rin[3]),
      .router_in10(rin[4]),  .router_in11(rin[5]),
      .router_in12(rin[6]),  .router_in13(rin[7]),
      .router_in20(rin[8]),  .router_in21(rin[9]),
      .router_in22(rin[10]), .router_in23(rin[11]),
      .router_in30(rin[12]), .router_in31(rin[13]),
      .router_in32(rin[14]), .router_in33(rin[15]),
      .buffer_in00(bin[0]),  .buffer_in01(bin[1]),
      .buffer_in02(bin[2]),  .buffer_in03(bin[3]),
      .buffer_in10(bin[4]),  .buffer_in11(bin[5]),
      .buffer_in12(bin[6]),  .buffer_in13(bin[7]),
      .buffer_in20(bin[8]),  .buffer_in21(bin[9]),
      .buffer_in22(bin[10]), .buffer_in23(bin[11]),
      .buffer_in30(bin[12]), .buffer_in31(bin[13]),
      .buffer_in32(bin[14]), .buffer_in33(bin[15]),
      .buffer_out00(bout[0]),  .buffer_out01(bout[1]),
      .buffer_out02(bout[2]),  .buffer_out03(bout[3]),
      .buffer_out10(bout[4]),  .buffer_out11(bout[5]),
      .buffer_out12(bout[6]),  .buffer_out13(bout[7]),
      .buffer_out20(bout[8]),  .buffer_out21(bout[9]),
      .buffer_out22(bout[10]), .buffer_out23(bout[11]),
      .buffer_out30(bout[12]), .buffer_out31(bout[13]),
      .buffer_out32(bout[14]), .buffer_out33(bout[15]),
      .router_out00(rout[0]),  .router_out01(rout[1]),
      .router_out02(rout[2]),  .router_out03(rout[3]),
      .router_out10(rout[4]),  .router_out11(rout[5]),
      .router_out12(rout[6]),  .router_out13(rout[7]),
      .router_out20(rout[8]),  .router_out21(rout[9]),
      .router_out22(rout[10]), .router_out23(rout[11]),
      .router_out30(rout[12]), .router_out31(rout[13]),
      .router_out32(rout[14]), .router_out33(rout[15])
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] or_outs();
      logic [31:0] acc_o;
      acc_o = '0;
      for (int i = 0; i < 16; i++) acc_o = acc_o | rout[i];
      return acc_o;
   endfunction

   task automatic clr_in();
      for (int i = 0; i < 16; i++) rin[i] = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk1);
   endtask

   task automatic send1(input int s, input logic [31:0] wd,
                        output int cp);
      @(negedge clk1);
      rin[s] = wd;
      sb[wd[31:28]].push_back(wd);
      cp = cyc + 1;
      @(negedge clk1);
      rin[s] = '0;
   endtask

   task automatic wait_del(input int d, input int base, input int bound);
      int t;
      t = 0;
      while (n_del[d] == base && t < bound) begin
         @(negedge clk1);
         #1;
         t++;
      end
      if (n_del[d] == base) chk("timeout", 32'd0, 32'd1);
   endtask

   // Match every ejected flit against the earliest pending one from its source
   always @(negedge clk1) begin
      if (rst) begin
         for (int d = 0; d < 16; d++) begin
            if (rout[d] != '0) begin
               n_del[d]++;
               del_cyc[d] = cyc;
               tot_del++;
               chk("dest", 32'(rout[d][31:28]), 32'(d));
               mi = -1;
               for (int i = 0; i < sb[d].size(); i++) begin
                  if (mi < 0 && sb[d][i][27:24] == rout[d][27:24]) mi = i;
               end
               if (mi < 0) begin
                  chk("spurious", rout[d], 32'd0);
               end else begin
                  chk("eject", rout[d], sb[d][mi]);
                  sb[d].delete(mi);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         n_del[i]   = 0;
         del_cyc[i] = 0;
      end
      clr_in();
      bin = '0;

      // reset state
      #1 rst = 1'b0;
      #1;
      chk("rst0_out", or_outs(), 32'd0);
      chk("rst0_bo", 32'(bout), 32'd0);
      idle(2);
      rst = 1'b1;
      idle(2);

      // mid-run reset with flits in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk1);
         w = 32'hF000_0010 + 32'(i);
         rin[0] = w;
         sb[15].push_back(w);
      end
      @(negedge clk1);
      clr_in();
      idle(1);
      @(posedge clk1);
      #2 rst = 1'b0;
      #1;
      chk("rst_out", or_outs(), 32'd0);
      chk("rst_bo", 32'(bout), 32'd0);
      for (int d = 0; d < 16; d++) sb[d].delete();
      idle(2);
      rst = 1'b1;
      b = tot_del;
      idle(15);
      chk("rst_quiet", 32'(tot_del - b), 32'd0);

      // one hop east
      b = n_del[1];
      send1(0, 32'h1000_00AA, cap);
      wait_del(1, b, 20);
      chk("t2_lat", 32'(del_cyc[1] - cap), 32'd2);
      idle(4);
      chk("t2_once", 32'(n_del[1] - b), 32'd1);

      // corner to corner, six hops
      b = n_del[15];
      send1(0, 32'hF000_0001, cap);
      wait_del(15, b, 30);
      chk("t3_lat", 32'(del_cyc[15] - cap), 32'd7);

      // self-addressed flit
      b = n_del[10];
      send1(10, 32'hA000_0005, cap);
      wait_del(10, b, 20);
      chk("t3_self", 32'(del_cyc[10] - cap), 32'd1);
      idle(3);

      // eject stall fills the local FIFO
      bin[15] = 1'b1;
      b = n_del[15];
      seq = 1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk1);
         if (!bout[15] && seq <= 6) begin
            w = 32'hF000_0000 + 32'(seq);
            rin[15] = w;
            sb[15].push_back(w);
            seq++;
         end else begin
            rin[15] = '0;
         end
      end
      @(negedge clk1);
      rin[15] = '0;
      chk("t4_acc", 32'(seq - 1), 32'd4);
      chk("t4_full", 32'(bout[15]), 32'd1);
      chk("t4_stall", 32'(n_del[15] - b), 32'd0);
      bin[15] = 1'b0;
      k = 0;
      while (seq <= 6 && k < 30) begin
         @(negedge clk1);
         if (!bout[15]) begin
            w = 32'hF000_0000 + 32'(seq);
            rin[15] = w;
            sb[15].push_back(w);
            seq++;
         end else begin
            rin[15] = '0;
         end
         k++;
      end
      @(negedge clk1);
      rin[15] = '0;
      k = 0;
      while (n_del[15] - b < 6 && k < 40) begin
         @(negedge clk1);
         k++;
      end
      idle(2);
      chk("t4_cnt", 32'(n_del[15] - b), 32'd6);
      chk("t4_left", 32'(sb[15].size()), 32'd0);

      // hotspot into node 33
      b = n_del[15];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk1);
         rin[0]  = {8'hF0, 24'(i + 1)};
         rin[3]  = {8'hF3, 24'(i + 1)};
         rin[12] = {8'hFC, 24'(i + 1)};
         rin[6]  = {8'hF6, 24'(i + 1)};
         sb[15].push_back(rin[0]);
         sb[15].push_back(rin[3]);
         sb[15].push_back(rin[12]);
         sb[15].push_back(rin[6]);
      end
      @(negedge clk1);
      clr_in();
      k = 0;
      while (n_del[15] - b < 12 && k < 60) begin
         @(negedge clk1);
         k++;
      end
      idle(3);
      chk("t5_cnt", 32'(n_del[15] - b), 32'd12);
      chk("t5_left", 32'(sb[15].size()), 32'd0);

      // random all-to-all traffic
      b = tot_del;
      acc = 0;
      for (int t = 0; t < 18; t++) begin
         @(negedge clk1);
         for (int n = 0; n < 16; n++) begin
            if (!bout[n]) begin
               dst = 4'($urandom_range(0, 15));
               w = {dst, 4'(n), 24'($urandom) | 24'h1};
               rin[n] = w;
               sb[dst].push_back(w);
               acc++;
            end else begin
               rin[n] = '0;
            end
         end
      end
      @(negedge clk1);
      clr_in();
      k = 0;
      while (tot_del - b < acc && k < 400) begin
         @(negedge clk1);
         k++;
      end
      idle(3);
      chk("t6_cnt", 32'(tot_del - b), 32'(acc));
      left = 0;
      for (int d = 0; d < 16; d++) left += sb[d].size();
      chk("t6_left", 32'(left), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
